// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg: AXI read-channel widths and arbiter state shared by the DDR read arbiter.
package ddr_axi_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W = 8;
  localparam int DATA_W = 32;
  localparam int BURST_W = 2;
  localparam int RESP_W = 2;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_arb_state_t;
  function automatic int idx_w(input int n);
    return n > 2 ? 2 : 1;
  endfunction
endpackage

// File: rtl/ddr_axi_rd_arbiter_if.sv
// ddr_axi_rd_arbiter_if: AXI AR+R channels for N ports, lane i packed at [i*W +: W].
interface ddr_axi_rd_arbiter_if import ddr_axi_pkg::*; #(parameter int N = 1);
  logic [N*ID_W-1:0] ar_id;
  logic [N*ADDR_W-1:0] ar_addr;
  logic [N*LEN_W-1:0] ar_len;
  logic [N*BURST_W-1:0] ar_burst;
  logic [N-1:0] ar_valid;
  logic [N-1:0] ar_ready;
  logic [N*ID_W-1:0] r_id;
  logic [N*DATA_W-1:0] r_data;
  logic [N*RESP_W-1:0] r_resp;
  logic [N-1:0] r_last;
  logic [N-1:0] r_valid;
  logic [N-1:0] r_ready;
  modport master (output ar_id, ar_addr, ar_len, ar_burst, ar_valid, r_ready,
                  input ar_ready, r_id, r_data, r_resp, r_last, r_valid);
  modport slave (input ar_id, ar_addr, ar_len, ar_burst, ar_valid, r_ready,
                 output ar_ready, r_id, r_data, r_resp, r_last, r_valid);
endinterface

// File: rtl/ddr_rr_pick.sv
// ddr_rr_pick: combinational round-robin picker, lowest requester at or after ptr wins.
module ddr_rr_pick import ddr_axi_pkg::*; #(
  parameter int NUM_M = 2,
  localparam int GW = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    gnt,
  output logic             any_req
);
  // Wrapped candidates first, then candidates at/after ptr override them.
  always_comb begin
    gnt = '0;
    for (int i = NUM_M - 1; i >= 0; i--) if (req[i] && i < int'(ptr)) gnt = GW'(i);
    for (int i = NUM_M - 1; i >= 0; i--) if (req[i] && i >= int'(ptr)) gnt = GW'(i);
  end
  assign any_req = |req;
endmodule

// File: rtl/ddr_axi_rd_arbiter.sv
// ddr_axi_rd_arbiter: shares one DDR AXI read slave between NUM_M masters,
// one whole burst at a time with round-robin grant and a sticky stall timeout.
module ddr_axi_rd_arbiter import ddr_axi_pkg::*; #(
  parameter int NUM_M = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  ddr_axi_rd_arbiter_if.slave  m,
  ddr_axi_rd_arbiter_if.master s,
  output logic [1:0] grant_id,
  output logic rd_timeout
);
  localparam int GW = idx_w(NUM_M);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  rd_arb_state_t state;
  logic [GW-1:0] g, rr_ptr, pick;
  logic [CW-1:0] stall;
  logic any_req, in_addr, in_data, ar_hs, r_hs;
  ddr_rr_pick #(.NUM_M(NUM_M)) u_pick (.req(m.ar_valid), .ptr(rr_ptr), .gnt(pick), .any_req(any_req));
  assign grant_id = 2'(g);
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  assign ar_hs = s.ar_valid & s.ar_ready;
  assign r_hs = in_data & s.r_valid & s.r_ready;
  always_comb begin
    s.ar_id = in_addr ? m.ar_id[g*ID_W +: ID_W] : '0;
    s.ar_addr = in_addr ? m.ar_addr[g*ADDR_W +: ADDR_W] : '0;
    s.ar_len = in_addr ? m.ar_len[g*LEN_W +: LEN_W] : '0;
    s.ar_burst = in_addr ? m.ar_burst[g*BURST_W +: BURST_W] : '0;
    s.ar_valid = in_addr & m.ar_valid[g];
    s.r_ready = in_data & m.r_ready[g];
    m.ar_ready = '0;
    m.r_id = '0;
    m.r_data = '0;
    m.r_resp = '0;
    m.r_last = '0;
    m.r_valid = '0;
    m.ar_ready[g] = in_addr & s.ar_ready;
    m.r_valid[g] = in_data & s.r_valid;
    m.r_last[g] = in_data & s.r_last;
    m.r_id[g*ID_W +: ID_W] = in_data ? s.r_id : '0;
    m.r_data[g*DATA_W +: DATA_W] = in_data ? s.r_data : '0;
    m.r_resp[g*RESP_W +: RESP_W] = in_data ? s.r_resp : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
      stall <= '0;
      rd_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          g <= pick;
          state <= ADDR;
        end
        ADDR: if (ar_hs) begin
          state <= DATA;
          stall <= '0;
        end
        DATA: begin
          if (r_hs && s.r_last) begin
            state <= IDLE;
            rr_ptr <= (g == GW'(NUM_M - 1)) ? '0 : g + 1'b1;
          end
          stall <= r_hs ? '0 : (stall == CW'(TIMEOUT_CYC)) ? stall : stall + 1'b1;
          if (!r_hs && stall == CW'(TIMEOUT_CYC - 1)) rd_timeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
